key_expansion_seq: RTL
======================

Name: key_expansion_seq

Overview:
- Iterative, runtime-configurable AES key schedule engine supporting AES-128, AES-192 and AES-256, selected per key.
- Generates one 32-bit schedule word per cycle using a single shared SubWord (4 S-boxes) instead of one S-box bank per round, trading latency for area.
- Stores the full schedule in an internal word file and serves 128-bit round keys through a registered read port to the cipher datapath in the engine.

Parameters:
- MAX_WORDS, 60, depth of the word file; fixed by AES-256 (4*(14+1)). Must be >= 60.
- EN_192, 1, when 0 the 192-bit mode is rejected as invalid, which saves the mod-6 logic.
- RK_ADDR_W, 4, width of the round-key index; covers rounds 0..14.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- start_i  in  1  request a new expansion; accepted only when ready_o=1.
- key_len_i  in  2  mode: 0=AES-128 (Nk=4, Nr=10), 1=AES-192 (Nk=6, Nr=12), 2=AES-256 (Nk=8, Nr=14), 3=invalid.
- key_i  in  256  cipher key, FIPS word 0 in [255:224]; 128-bit keys occupy [255:128], 192-bit keys [255:64], unused bits ignored.
- ready_o  out  1  high in IDLE and DONE.
- busy_o  out  1  high while expanding.
- done_o  out  1  one-cycle pulse when the last word is written.
- err_o  out  1  one-cycle pulse when start_i is accepted with an invalid mode.
- key_valid_o  out  1  level; the schedule is complete and matches the last accepted key.
- nr_o  out  4  Nr of the stored schedule (10/12/14); 0 after reset.
- rk_addr_i  in  RK_ADDR_W  round-key index.
- rk_o  out  128  registered round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in [127:96].

Behaviour:
- Reset values: ready_o=1, busy_o=0, done_o=0, err_o=0, key_valid_o=0, nr_o=0, rk_o=0.
  - Word file contents are don't-care after reset.
  - Rcon register resets to 8'h01 and the word counter to 0.
- FSM states: IDLE, LOAD, EXPAND, DONE.
- IDLE/DONE + start_i with a valid mode -> LOAD.
  - key_valid_o clears in the same edge.
  - Mode, Nk and Nr are latched.
- IDLE/DONE + start_i with an invalid mode (3, or 1 when EN_192=0):
  - err_o pulses for one cycle.
  - State, key_valid_o and stored schedule are unchanged.
- LOAD (1 cycle): writes w[0..Nk-1] from key_i, sets i=Nk and Rcon=01, -> EXPAND.
- EXPAND: one word per cycle, with t=w[i-1].
  - i mod Nk == 0: w[i] = w[i-Nk] ^ SubWord(RotWord(t)) ^ {Rcon, 24'h0}, then Rcon <= xtime(Rcon). xtime: shift left, XOR 8'h1b on carry.
  - Nk==8 and i mod 8 == 4: w[i] = w[i-8] ^ SubWord(t).
  - Otherwise: w[i] = w[i-Nk] ^ t.
  - RotWord(a,b,c,d) = (b,c,d,a). SubWord applies the AES S-box to each byte.
  - i mod Nk is tracked by a wrapping counter, with no divider.
  - On i == 4*(Nr+1)-1, write the final word, pulse done_o, set key_valid_o=1, nr_o=Nr, -> DONE.
- Latency from the start_i accept edge to the done_o cycle is 1+(4*(Nr+1)-Nk): 41 for AES-128, 47 for AES-192, 53 for AES-256.
- start_i while busy is ignored; no queuing.
- start_i in the same cycle as done_o is ignored, because ready_o is still 0 in that cycle.
- Read port:
  - rk_o updates 1 cycle after rk_addr_i and is always active.
  - When rk_addr_i > nr_o, rk_o=0.
  - While key_valid_o=0, contents are undefined; consumers gate on key_valid_o.
- rst_i mid-expansion: returns to IDLE next edge, with all outputs at reset values and no done_o pulse.
- rst_i has priority over start_i.

Test Plan:
- AES-128 (FIPS-197 A.1), key 2b7e151628aed2a6abf7158809cf4f3c -> done_o 41 cycles after accept; rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6; nr_o=10; rk_addr=11 -> rk_o=0.
- AES-192 (A.2), key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done_o at 47 cycles; w[51]=01002202; nr_o=12.
- AES-256 (A.3), key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done_o at 53 cycles; w[59]=706c631e; rk[0] equals key[255:128].
- Back-to-back operation: AES-256 then AES-128 with start_i held high through busy -> second accept on the cycle after done_o; key_valid_o drops for 41 cycles, then rk[10] matches the AES-128 vector.
- key_len_i=3, and key_len_i=1 with EN_192=0 -> err_o 1-cycle pulse; key_valid_o and rk_o from the prior schedule are unchanged.
- rst_i asserted at cycle 20 of an AES-256 expansion -> next cycle ready_o=1, key_valid_o=0, nr_o=0, no done_o; a fresh AES-128 start then completes correctly.

Source files
------------

// File: rtl/key_expansion_seq.sv
// Iterative AES-128/192/256 key schedule engine.
// One schedule word is produced per cycle through a single shared SubWord,
// and the words are kept in a word file. A registered port serves 128-bit round keys.
module key_expansion_seq #(
   parameter int unsigned MAX_WORDS = 60,
   parameter bit          EN_192    = 1'b1,
   parameter int unsigned RK_ADDR_W = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [1:0]           key_len_i,
   input  logic [255:0]         key_i,
   output logic                 ready_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic                 key_valid_o,
   output logic [3:0]           nr_o,
   input  logic [RK_ADDR_W-1:0] rk_addr_i,
   output logic [127:0]         rk_o
);

   localparam int unsigned IW = $clog2(MAX_WORDS);

   // AES S-box, entry 0 in the top byte
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {StIdle, StLoad, StExpand, StDone} state_e;

   state_e          state_q;
   logic [3:0]      nk_q, nr_q, nr_out_q;
   logic [IW-1:0]   i_q, last_q;
   logic [2:0]      phase_q;      // i mod Nk
   logic [7:0]      rcon_q;
   logic            ready_q, busy_q, done_q, err_q, kv_q;
   logic [127:0]    rk_q;
   logic [31:0]     wfile [MAX_WORDS];

   logic            mode_ok;
   logic [3:0]      nk_sel, nr_sel;
   logic [31:0]     t_word, prev_word, sub_in, sub_out, new_word;
   logic [7:0]      rcon_next;
   logic [IW-1:0]   rd_base;

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[{~x, 3'b000} +: 8];
   endfunction

   // decode the requested key length
   always_comb begin
      mode_ok = 1'b0;
      nk_sel  = 4'd4;
      nr_sel  = 4'd10;
      case (key_len_i)
         2'd0: begin mode_ok = 1'b1;   nk_sel = 4'd4; nr_sel = 4'd10; end
         2'd1: begin mode_ok = EN_192; nk_sel = 4'd6; nr_sel = 4'd12; end
         2'd2: begin mode_ok = 1'b1;   nk_sel = 4'd8; nr_sel = 4'd14; end
         default: mode_ok = 1'b0;
      endcase
   end

   // next schedule word w[i] from w[i-1] and w[i-Nk]
   always_comb begin
      t_word    = wfile[i_q - IW'(1)];
      prev_word = wfile[i_q - IW'(nk_q)];
      sub_in    = (phase_q == 3'd0) ? {t_word[23:0], t_word[31:24]} : t_word;
      sub_out   = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                   sbox(sub_in[15:8]), sbox(sub_in[7:0])};
      rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      if (phase_q == 3'd0) begin
         new_word = prev_word ^ sub_out ^ {rcon_q, 24'h0};
      end else if (nk_q == 4'd8 && phase_q == 3'd4) begin
         new_word = prev_word ^ sub_out;
      end else begin
         new_word = prev_word ^ t_word;
      end
      rd_base = IW'({rk_addr_i, 2'b00});
   end

   // control FSM with registered status outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         kv_q     <= 1'b0;
         nr_out_q <= 4'd0;
         nk_q     <= 4'd4;
         nr_q     <= 4'd10;
         last_q   <= '0;
         i_q      <= '0;
         phase_q  <= 3'd0;
         rcon_q   <= 8'h01;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            StIdle, StDone: begin
               // ready rises one cycle after done so a start in the done cycle is dropped
               ready_q <= 1'b1;
               if (start_i && ready_q) begin
                  if (mode_ok) begin
                     state_q <= StLoad;
                     ready_q <= 1'b0;
                     busy_q  <= 1'b1;
                     kv_q    <= 1'b0;
                     nk_q    <= nk_sel;
                     nr_q    <= nr_sel;
                     last_q  <= IW'({nr_sel, 2'b11});
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            StLoad: begin
               i_q     <= IW'(nk_q);
               phase_q <= 3'd0;
               rcon_q  <= 8'h01;
               state_q <= StExpand;
            end
            StExpand: begin
               if (phase_q == 3'd0) rcon_q <= rcon_next;
               phase_q <= (phase_q == 3'(nk_q - 4'd1)) ? 3'd0 : phase_q + 3'd1;
               i_q     <= i_q + IW'(1);
               if (i_q == last_q) begin
                  state_q  <= StDone;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  kv_q     <= 1'b1;
                  nr_out_q <= nr_q;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // word file writes: key words on load, one expanded word per cycle after
   always_ff @(posedge clk_i) begin
      if (state_q == StLoad) begin
         for (int k = 0; k < 8; k++) begin
            if (4'(k) < nk_q) wfile[k] <= key_i[255-32*k -: 32];
         end
      end else if (state_q == StExpand) begin
         wfile[i_q] <= new_word;
      end
   end

   // registered round-key read port, zero beyond the stored Nr
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rk_q <= '0;
      end else if (int'(rk_addr_i) > int'(nr_out_q)) begin
         rk_q <= '0;
      end else begin
         rk_q <= {wfile[rd_base], wfile[rd_base + IW'(1)],
                  wfile[rd_base + IW'(2)], wfile[rd_base + IW'(3)]};
      end
   end

   assign ready_o     = ready_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign key_valid_o = kv_q;
   assign nr_o        = nr_out_q;
   assign rk_o        = rk_q;

endmodule
